// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the sync generator and the overlay
// stages. Default constants describe 640x480@60 with an 800x525 total raster.
package vga_timing_pkg;

  localparam int COORD_W     = 10;
  localparam int COORD_LIMIT = 1 << COORD_W;
  localparam int FRAME_CNT_W = 8;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Negative-polarity syncs for the default mode.
  localparam bit DEF_SYNC_ACTIVE = 1'b0;

  localparam int DEF_PIPE_DELAY = 1;
  localparam int MIN_PIPE_DELAY = 1;
  localparam int MAX_PIPE_DELAY = 4;

  function automatic int span_total(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  localparam int DEF_H_TOTAL = span_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = span_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  // Decode outputs that travel together through the alignment delay line.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
  } sync_bundle_t;

  localparam int SYNC_BUNDLE_W = $bits(sync_bundle_t);

  // Inclusive window test on a raster coordinate.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Electrical sync level for a logical asserted/deasserted state.
  function automatic logic sync_level(input logic asserted, input logic polarity);
    return asserted ? polarity : ~polarity;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster bus between the sync generator and its consumers (overlay stages).
// The generator side owns everything except the pixel tick.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic                   pix_en;
  logic [COORD_W-1:0]     x;
  logic [COORD_W-1:0]     y;
  logic                   display_on;
  logic                   hsync;
  logic                   vsync;
  logic                   hsync_d;
  logic                   vsync_d;
  logic                   display_on_d;
  logic                   line_start;
  logic                   frame_start;
  logic [FRAME_CNT_W-1:0] frame_count;

  modport master (
    input  pix_en,
    output x, y, display_on, hsync, vsync,
    output hsync_d, vsync_d, display_on_d,
    output line_start, frame_start, frame_count
  );

  modport slave (
    output pix_en,
    input  x, y, display_on, hsync, vsync,
    input  hsync_d, vsync_d, display_on_d,
    input  line_start, frame_start, frame_count
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that re-times the sync/blanking bundle so it lines
// up with a downstream stage's registered output. Shifts on every clk, not on
// pixel ticks, because the downstream latency is counted in clk cycles.
module sync_delay_line #(
  parameter int               DEPTH     = 1,
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift one stage per clk; reset loads the idle pattern into every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: x/y counters, sync/blanking decode that is
// registered alongside x/y, line/frame strobes, a frame counter, and a
// delayed copy of the decode outputs for the overlay pipeline.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY   = DEF_H_DISPLAY,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_DISPLAY   = DEF_V_DISPLAY,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter bit SYNC_ACTIVE = DEF_SYNC_ACTIVE,
  parameter int PIPE_DELAY  = DEF_PIPE_DELAY
) (
  input logic            clk,
  input logic            reset,
  vga_sync_gen_if.master bus
);

  localparam int H_TOTAL = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the coordinate range");
  end
  if (PIPE_DELAY < MIN_PIPE_DELAY || PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_delay
    $error("vga_sync_gen: PIPE_DELAY out of range");
  end

  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS_END  = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS_END  = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] H_SYNC_LO  = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] H_SYNC_HI  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] V_SYNC_LO  = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] V_SYNC_HI  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam sync_bundle_t SYNC_IDLE = '{hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE, display_on: 1'b0};

  logic [COORD_W-1:0]     r_x;
  logic [COORD_W-1:0]     r_y;
  logic                   r_display_on;
  logic                   r_hsync;
  logic                   r_vsync;
  logic                   r_line_start;
  logic                   r_frame_start;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  logic [COORD_W-1:0] w_x_next;
  logic [COORD_W-1:0] w_y_next;
  logic               w_display_on_next;
  logic               w_hsync_next;
  logic               w_vsync_next;
  logic               w_line_start;
  logic               w_frame_start;

  sync_bundle_t w_sync_now;
  sync_bundle_t w_sync_dly;

  // Next raster position: advance x on a tick, carry into y at end of line.
  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (bus.pix_en) begin
      if (r_x == H_LAST) begin
        w_x_next = '0;
        w_y_next = (r_y == V_LAST) ? '0 : r_y + COORD_W'(1);
      end else begin
        w_x_next = r_x + COORD_W'(1);
      end
    end
  end

  // Decode from the next position so the registered flags match registered x/y.
  always_comb begin
    w_display_on_next = (w_x_next < H_VIS_END) && (w_y_next < V_VIS_END);
    w_hsync_next      = sync_level(in_window(w_x_next, H_SYNC_LO, H_SYNC_HI), SYNC_ACTIVE);
    w_vsync_next      = sync_level(in_window(w_y_next, V_SYNC_LO, V_SYNC_HI), SYNC_ACTIVE);
    w_line_start      = bus.pix_en && (w_x_next == '0);
    w_frame_start     = w_line_start && (w_y_next == '0);
  end

  // Raster state; position and decode only move on pixel ticks, strobes
  // are cleared on every non-tick clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_display_on  <= 1'b0;
      r_hsync       <= ~SYNC_ACTIVE;
      r_vsync       <= ~SYNC_ACTIVE;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
      if (bus.pix_en) begin
        r_x          <= w_x_next;
        r_y          <= w_y_next;
        r_display_on <= w_display_on_next;
        r_hsync      <= w_hsync_next;
        r_vsync      <= w_vsync_next;
      end
      if (w_frame_start) begin
        r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
      end
    end
  end

  assign w_sync_now = '{hsync: r_hsync, vsync: r_vsync, display_on: r_display_on};

  sync_delay_line #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     (SYNC_BUNDLE_W),
    .RESET_VAL (SYNC_IDLE)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_sync_now),
    .o_q   (w_sync_dly)
  );

  assign bus.x            = r_x;
  assign bus.y            = r_y;
  assign bus.display_on   = r_display_on;
  assign bus.hsync        = r_hsync;
  assign bus.vsync        = r_vsync;
  assign bus.line_start   = r_line_start;
  assign bus.frame_start  = r_frame_start;
  assign bus.frame_count  = r_frame_count;
  assign bus.hsync_d      = w_sync_dly.hsync;
  assign bus.vsync_d      = w_sync_dly.vsync;
  assign bus.display_on_d = w_sync_dly.display_on;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Three instances share clk/reset/pix_en:
//   A: default 640x480 timing, PIPE_DELAY=1
//   B: 8-pixel lines with default vertical timing, PIPE_DELAY=3
//   C: 8x5 raster, PIPE_DELAY=1 (fast frame-counter wrap)
// Expected raster values come from the tick index since reset release.
module tb_vga_sync_gen;

  logic clk;
  logic reset;
  logic pix_en;

  int checks = 0;
  int errors = 0;
  int k_cur  = 0;

  localparam int K_MAX = 10248;

  vga_sync_gen_if if_a ();
  vga_sync_gen_if if_b ();
  vga_sync_gen_if if_c ();

  assign if_a.pix_en = pix_en;
  assign if_b.pix_en = pix_en;
  assign if_c.pix_en = pix_en;

  vga_sync_gen #(.PIPE_DELAY(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));

  vga_sync_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .PIPE_DELAY(3)
  ) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  vga_sync_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .PIPE_DELAY(1)
  ) dut_c (.clk(clk), .reset(reset), .bus(if_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at k=%0d", k_cur);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %0d want %0d", name, k_cur, act, exp);
    end
  endtask

  typedef struct {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic de;
  } exp_t;

  // Position/decode after k ticks since reset release (k<=0: reset state).
  // Negative sync polarity for all instances.
  function automatic exp_t model(input int k, input int hd, input int hf, input int hs,
                                 input int hb, input int vd, input int vf, input int vs,
                                 input int vb);
    exp_t e;
    int ht = hd + hf + hs + hb;
    int vt = vd + vf + vs + vb;
    if (k <= 0) begin
      e.x = ht - 1;
      e.y = vt - 1;
    end else begin
      e.x = (k - 1) % ht;
      e.y = ((k - 1) / ht) % vt;
    end
    e.hs = !(e.x >= hd + hf && e.x < hd + hf + hs);
    e.vs = !(e.y >= vd + vf && e.y < vd + vf + vs);
    e.de = (e.x < hd) && (e.y < vd);
    return e;
  endfunction

  function automatic exp_t mod_a(input int k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic exp_t mod_b(input int k);
    return model(k, 4, 1, 2, 1, 480, 10, 2, 33);
  endfunction
  function automatic exp_t mod_c(input int k);
    return model(k, 4, 1, 2, 1, 2, 1, 1, 1);
  endfunction

  typedef struct {
    logic rst;
    logic pe;
    int   x;
    int   y;
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
    int   fc;
    logic hsd;
    logic ded;
  } vec_t;

  vec_t tbl [8];

  initial begin
    exp_t e, ep;

    //             rst   pe    x    y    de    hs    vs    ls    fs    fc hsd   ded
    tbl[0] = '{1'b1, 1'b1, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b1,   2,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b1,   3,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1};

    reset  = 1'b1;
    pix_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Table: reset, first tick, and a 1,0,0,1 pix_en pattern on instance A.
    for (int i = 0; i < 8; i++) begin
      reset  = tbl[i].rst;
      pix_en = tbl[i].pe;
      @(posedge clk);
      #1;
      k_cur = -100 - i;
      chk("tbl_x",   if_a.x,            tbl[i].x);
      chk("tbl_y",   if_a.y,            tbl[i].y);
      chk("tbl_de",  if_a.display_on,   tbl[i].de);
      chk("tbl_hs",  if_a.hsync,        tbl[i].hs);
      chk("tbl_vs",  if_a.vsync,        tbl[i].vs);
      chk("tbl_ls",  if_a.line_start,   tbl[i].ls);
      chk("tbl_fs",  if_a.frame_start,  tbl[i].fs);
      chk("tbl_fc",  if_a.frame_count,  tbl[i].fc);
      chk("tbl_hsd", if_a.hsync_d,      tbl[i].hsd);
      chk("tbl_ded", if_a.display_on_d, tbl[i].ded);
    end

    // Mid-run reset takes effect without a clock edge.
    reset = 1'b1;
    #2;
    k_cur = -1;
    chk("rst_x",   if_a.x,            799);
    chk("rst_y",   if_a.y,            524);
    chk("rst_de",  if_a.display_on,   0);
    chk("rst_hs",  if_a.hsync,        1);
    chk("rst_vs",  if_a.vsync,        1);
    chk("rst_fc",  if_a.frame_count,  0);
    chk("rst_ded", if_a.display_on_d, 0);
    chk("rst_c_x", if_c.x,            7);
    chk("rst_c_y", if_c.y,            4);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    pix_en = 1'b1;

    // Continuous ticks: line sweep on A, frame sweep on B, 256+ frames on C.
    for (int k = 1; k <= K_MAX; k++) begin
      @(posedge clk);
      #1;
      k_cur = k;
      if (k <= 801) begin
        e  = mod_a(k);
        ep = mod_a(k - 1);
        chk("a_x",   if_a.x,            e.x);
        chk("a_y",   if_a.y,            e.y);
        chk("a_de",  if_a.display_on,   e.de);
        chk("a_hs",  if_a.hsync,        e.hs);
        chk("a_vs",  if_a.vsync,        e.vs);
        chk("a_ls",  if_a.line_start,   e.x == 0);
        chk("a_fs",  if_a.frame_start,  e.x == 0 && e.y == 0);
        chk("a_fc",  if_a.frame_count,  1);
        chk("a_hsd", if_a.hsync_d,      ep.hs);
        chk("a_ded", if_a.display_on_d, ep.de);
      end
      if (k <= 4208) begin
        e  = mod_b(k);
        ep = mod_b(k - 3);
        chk("b_x",   if_b.x,            e.x);
        chk("b_y",   if_b.y,            e.y);
        chk("b_de",  if_b.display_on,   e.de);
        chk("b_hs",  if_b.hsync,        e.hs);
        chk("b_vs",  if_b.vsync,        e.vs);
        chk("b_fs",  if_b.frame_start,  e.x == 0 && e.y == 0);
        chk("b_fc",  if_b.frame_count,  (k - 1) / 4200 + 1);
        chk("b_hsd", if_b.hsync_d,      ep.hs);
        chk("b_vsd", if_b.vsync_d,      ep.vs);
        chk("b_ded", if_b.display_on_d, ep.de);
      end
      e  = mod_c(k);
      ep = mod_c(k - 1);
      chk("c_x",   if_c.x,           e.x);
      chk("c_y",   if_c.y,           e.y);
      chk("c_de",  if_c.display_on,  e.de);
      chk("c_vs",  if_c.vsync,       e.vs);
      chk("c_ls",  if_c.line_start,  e.x == 0);
      chk("c_fs",  if_c.frame_start, e.x == 0 && e.y == 0);
      chk("c_fc",  if_c.frame_count, ((k - 1) / 40 + 1) % 256);
      chk("c_vsd", if_c.vsync_d,     ep.vs);
      if (k == 10200) chk("c_fc_255", if_c.frame_count, 255);
      if (k == 10201) begin
        chk("c_fc_wrap", if_c.frame_count, 0);
        chk("c_fs_wrap", if_c.frame_start, 1);
      end
    end

    // Gating at end of a C line: two idle clks must not fire strobes or move.
    pix_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      k_cur = K_MAX;
      e = mod_c(K_MAX);
      chk("gate_c_x",  if_c.x,           e.x);
      chk("gate_c_ls", if_c.line_start,  0);
      chk("gate_c_fs", if_c.frame_start, 0);
      chk("gate_c_de", if_c.display_on,  e.de);
      e = mod_a(K_MAX);
      chk("gate_a_x",  if_a.x,           e.x);
      chk("gate_a_hs", if_a.hsync,       e.hs);
      chk("gate_a_ls", if_a.line_start,  0);
    end
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    k_cur = K_MAX + 1;
    e = mod_c(K_MAX + 1);
    chk("resume_c_x",  if_c.x,          e.x);
    chk("resume_c_y",  if_c.y,          e.y);
    chk("resume_c_ls", if_c.line_start, 1);
    e = mod_a(K_MAX + 1);
    chk("resume_a_x",  if_a.x,          e.x);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator directly upstream of the text overlay stages; produces the x/y pixel coordinates they consume.
- Also produces hsync/vsync/display_on, plus copies delayed to line up with the overlay's one-clock registered output.
- Adds line/frame strobes and a frame counter for animation logic.
- Default timing is 640x480@60 (800x525 total) at one pixel per pix_en tick.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hsync/vsync when asserted (0 = negative polarity)
- PIPE_DELAY, 1, clk cycles of delay on the *_d outputs; legal range 1..4

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel tick; counters advance only on clk edges where pix_en=1 (tie high for clk = pixel clock)
- x  out  10  horizontal position, 0..H_TOTAL-1
- y  out  10  vertical position, 0..V_TOTAL-1
- display_on  out  1  high when x<H_DISPLAY and y<V_DISPLAY
- hsync  out  1  horizontal sync, aligned with x/y
- vsync  out  1  vertical sync, aligned with x/y
- hsync_d  out  1  hsync delayed PIPE_DELAY clk cycles
- vsync_d  out  1  vsync delayed PIPE_DELAY clk cycles
- display_on_d  out  1  display_on delayed PIPE_DELAY clk cycles
- line_start  out  1  one-clk pulse when x becomes 0
- frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)
- frame_count  out  8  frames started since reset, wraps 255->0

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both must be ≤1024 (checked at elaboration).
- Reset (async assert, released on clk): x=H_TOTAL-1 (799), y=V_TOTAL-1 (524), display_on=0, hsync=vsync=!SYNC_ACTIVE, all *_d outputs = (!SYNC_ACTIVE, !SYNC_ACTIVE, 0), line_start=0, frame_start=0, frame_count=0.
- Tick (pix_en=1):
  - If x==H_TOTAL-1: x<=0; then y<=0 if y==V_TOTAL-1, else y+1.
  - Otherwise x<=x+1 and y holds.
  - pix_en=0: x, y, display_on, hsync, vsync hold; line_start=frame_start=0.
- Decode: display_on, hsync and vsync are registers computed from the next x/y. They change on the same edge as x/y and always describe the current registered x/y (zero-latency relative to x/y).
  - hsync asserted for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = 656..751.
  - vsync asserted for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = 490..491, for the whole line including blanking.
- Strobes:
  - line_start=1 for exactly the clk cycle in which registered x==0 after a tick.
  - frame_start likewise when x==0 and y==0.
  - frame_count increments on the same edge that raises frame_start, so the first frame after reset reads 1.
- Delay line: shift register clocked every clk, independent of pix_en, so the *_d outputs match the overlay's one-clk registered latency. With PIPE_DELAY=N, hsync_d(t)=hsync(t-N).
- Reset mid-frame: all state returns to reset values immediately. The first tick after release yields (0,0) with both strobes.

Decomposition:
- Shared package vga_timing_pkg: 640x480 timing constants, derived H_TOTAL/V_TOTAL, coordinate width (10), sync polarity constant; reused by the overlay stages.
- One sub-module, sync_delay_line: parameterised-depth, 3-bit-wide shift register with async reset value, generating the *_d outputs.

Test Plan:
- Reset: assert reset mid-run -> immediately x=799, y=524, display_on=0, hsync=vsync=1, frame_count=0. Release, first pix_en tick -> x=0, y=0, display_on=1, line_start=1, frame_start=1, frame_count=1.
- Horizontal timing: sweep one line -> hsync=0 exactly for x=656..751, display_on=0 from x=640, line_start high once; at x=799->0, y increments.
- Vertical timing: sweep full frame -> vsync=0 exactly on y=490 and 491 (all x), display_on=0 for y≥480, wrap y=524,x=799 -> (0,0) with frame_start.
- pix_en gating: pix_en pattern 1,0,0,1 -> x advances by 2 over 4 clks, strobes never high on pix_en=0 cycles, decode outputs hold.
- Delay alignment: PIPE_DELAY=1 and 3 -> hsync_d/vsync_d/display_on_d equal the undelayed signals shifted by exactly 1 and 3 clks, including across reset release.
- Counter wrap: tiny timing (H=4/1/2/1, V=2/1/1/1) run 256 frames -> frame_count 255->0 with frame_start pulsing on the wrap edge.
